// File: rtl/fifo_flex.sv
// fifo_flex: parametrised single-clock FIFO with FWFT/registered read, occupancy count and
// programmable almost flags. Define FIFO_FLEX_ERR_EN to add sticky overflow/underflow flags.
module fifo_flex #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8,
   parameter int FWFT       = 0,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wren,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  rden,
`ifdef FIFO_FLEX_ERR_EN
   input  logic                  err_clr,
   output logic                  overflow,
   output logic                  underflow,
`endif
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CW-1:0]         count
);

   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

   if (DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_param_err
      $error("fifo_flex: illegal DEPTH/AE_THRESH/AF_THRESH combination");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]         rptr_q, rptr_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rd_acc, wr_acc;

   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;

   // A full FIFO still takes a write when the head is popped in the same cycle.
   always_comb begin
      rd_acc   = rden && !empty;
      wr_acc   = wren && (!full || rd_acc);
      rptr_d   = rptr_q;
      wptr_d   = wptr_q;
      count_d  = count_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (rd_acc) begin
         rptr_d   = (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
         rdata_d  = mem[rptr_q];
         rvalid_d = 1'b1;
      end
      if (wr_acc) begin
         wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
         count_d = count_q + 1'b1;
      end else if (rd_acc && !wr_acc) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q   <= '0;
         wptr_q   <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rptr_q   <= rptr_d;
         wptr_q   <= wptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Storage is never cleared; a pass-through write lands after the old word was read out.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wptr_q] <= i_data;
      end
   end

   always_comb begin
      o_data  = (FWFT != 0) ? mem[rptr_q] : rdata_q;
      o_valid = (FWFT != 0) ? !empty : rvalid_q;
   end

`ifdef FIFO_FLEX_ERR_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Setting has priority over a coincident clear so no event is lost.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wren && full && !rd_acc) begin
         overflow_d = 1'b1;
      end
      if (rden && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Testbench for fifo_flex: a registered-read DEPTH=16 and an FWFT DEPTH=5 instance share one
// stimulus stream and are each compared against a queue-based reference model.
module tb_fifo_flex;

   logic       clk = 1'b0;
   logic       rst;
   logic       wren;
   logic       rden;
   logic [7:0] i_data;
   logic       err_clr;

   logic [7:0] odA, odB;
   logic       ovA, fullA, emptyA, afA, aeA;
   logic       ovB, fullB, emptyB, afB, aeB;
   logic [4:0] cntA;
   logic [2:0] cntB;
`ifdef FIFO_FLEX_ERR_EN
   logic       ovfA, unfA, ovfB, unfB;
`endif

   logic [7:0] mq [2][$];
   int         depthM [2] = '{16, 5};
   int         afM    [2] = '{14, 3};
   int         aeM    [2] = '{2, 2};
   int         fwftM  [2] = '{0, 1};
   bit         voutM  [2];
   logic [7:0] doutM  [2];
   bit         ovfM   [2];
   bit         unfM   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_flex #(.DEPTH(16), .DATA_WIDTH(8), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) dutA (
      .clk(clk), .rst(rst), .wren(wren), .i_data(i_data), .rden(rden),
`ifdef FIFO_FLEX_ERR_EN
      .err_clr(err_clr), .overflow(ovfA), .underflow(unfA),
`endif
      .o_data(odA), .o_valid(ovA), .full(fullA), .empty(emptyA),
      .almost_full(afA), .almost_empty(aeA), .count(cntA)
   );

   fifo_flex #(.DEPTH(5), .DATA_WIDTH(8), .FWFT(1), .AF_THRESH(3), .AE_THRESH(2)) dutB (
      .clk(clk), .rst(rst), .wren(wren), .i_data(i_data), .rden(rden),
`ifdef FIFO_FLEX_ERR_EN
      .err_clr(err_clr), .overflow(ovfB), .underflow(unfB),
`endif
      .o_data(odB), .o_valid(ovB), .full(fullB), .empty(emptyB),
      .almost_full(afB), .almost_empty(aeB), .count(cntB)
   );

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: a FIFO is an ordered list of at most depth words.
   task automatic modelStep(input int k);
      int         sz;
      bit         rdAcc, wrAcc;
      logic [7:0] w;
      sz = mq[k].size();
      if (rst) begin
         mq[k].delete();
         voutM[k] = 0;
         doutM[k] = 8'h00;
         ovfM[k]  = 0;
         unfM[k]  = 0;
      end else begin
         rdAcc = rden && (sz > 0);
         wrAcc = wren && ((sz < depthM[k]) || rdAcc);
         if (wren && sz == depthM[k] && !rdAcc) ovfM[k] = 1;
         else if (err_clr) ovfM[k] = 0;
         if (rden && sz == 0) unfM[k] = 1;
         else if (err_clr) unfM[k] = 0;
         voutM[k] = 0;
         if (rdAcc) begin
            w = mq[k].pop_front();
            if (fwftM[k] == 0) begin
               doutM[k] = w;
               voutM[k] = 1;
            end
         end
         if (wrAcc) mq[k].push_back(i_data);
      end
   endtask

   task automatic checkDut(input int k, input logic [31:0] cnt, input logic fl, input logic em,
                           input logic af, input logic ae, input logic ov, input logic [7:0] od);
      int    sz;
      string n;
      sz = mq[k].size();
      n  = (k == 0) ? "A" : "B";
      checkVal({n, ".count"}, cnt, sz);
      checkVal({n, ".full"}, fl, (sz == depthM[k]));
      checkVal({n, ".empty"}, em, (sz == 0));
      checkVal({n, ".almost_full"}, af, (sz >= afM[k]));
      checkVal({n, ".almost_empty"}, ae, (sz <= aeM[k]));
      if (fwftM[k] != 0) begin
         checkVal({n, ".o_valid"}, ov, (sz > 0));
         if (sz > 0) checkVal({n, ".o_data"}, od, mq[k][0]);
      end else begin
         checkVal({n, ".o_valid"}, ov, voutM[k]);
         checkVal({n, ".o_data"}, od, doutM[k]);
      end
   endtask

   task automatic checkOutput();
      checkDut(0, cntA, fullA, emptyA, afA, aeA, ovA, odA);
      checkDut(1, cntB, fullB, emptyB, afB, aeB, ovB, odB);
`ifdef FIFO_FLEX_ERR_EN
      checkVal("A.overflow", ovfA, ovfM[0]);
      checkVal("A.underflow", unfA, unfM[0]);
      checkVal("B.overflow", ovfB, ovfM[1]);
      checkVal("B.underflow", unfB, unfM[1]);
`endif
   endtask

   task automatic applyStimulus(input logic r, input logic w, input logic rd,
                                input logic [7:0] d, input logic c);
      rst     = r;
      wren    = w;
      rden    = rd;
      i_data  = d;
      err_clr = c;
      @(posedge clk);
      modelStep(0);
      modelStep(1);
      #1;
      checkOutput();
   endtask

   initial begin
      rst = 1'b1; wren = 1'b0; rden = 1'b0; i_data = 8'h00; err_clr = 1'b0;
      $display("[TB] reset");
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(1, 0, 0, 8'h00, 0);

      $display("[TB] fill 0x11..0x20, then a dropped write");
      for (int i = 0; i < 16; i++) applyStimulus(0, 1, 0, 8'(8'h11 + i), 0);
      applyStimulus(0, 1, 0, 8'h99, 0);

      $display("[TB] full pass-through of 0x77");
      applyStimulus(0, 1, 1, 8'h77, 0);

      $display("[TB] drain with rden held, one read past empty");
      for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 8'h00, 0);
      applyStimulus(0, 0, 0, 8'h00, 1);
      applyStimulus(0, 0, 0, 8'h00, 0);

      $display("[TB] single word 0xA5 then pop");
      applyStimulus(1, 0, 0, 8'h00, 0);
      applyStimulus(0, 1, 0, 8'hA5, 0);
      applyStimulus(0, 0, 1, 8'h00, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);

      $display("[TB] prefill 2 then 12 cycles of simultaneous read/write");
      applyStimulus(0, 1, 0, 8'h30, 0);
      applyStimulus(0, 1, 0, 8'h31, 0);
      for (int i = 0; i < 12; i++) applyStimulus(0, 1, 1, 8'(8'h32 + i), 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 8'h00, 0);

      $display("[TB] reset with 7 words stored");
      applyStimulus(1, 0, 0, 8'h00, 0);
      for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 8'(8'h50 + i), 0);
      applyStimulus(1, 1, 1, 8'hEE, 0);
      applyStimulus(0, 0, 0, 8'h00, 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 800; i++) begin
         int  wrBias;
         logic r, w, rd, c;
         wrBias = ((i / 60) % 2 == 0) ? 75 : 25;
         r  = ($urandom_range(0, 199) == 0);
         w  = ($urandom_range(0, 99) < wrBias);
         rd = ($urandom_range(0, 99) < (100 - wrBias));
         c  = ($urandom_range(0, 24) == 0);
         applyStimulus(r, w, rd, 8'($urandom), c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
